g_alu_issue: RTL and testbench

//  Issue stage directly upstream of the ALU. Accepts decoded ops from decode/regfile-read.

---
 rtl/g_rv_pkg.sv | 20 ++
 rtl/g_skid_buf.sv | 94 +++++++++
 rtl/g_alu_issue.sv | 92 +++++++++
 tb/tb_g_alu_issue.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/g_rv_pkg.sv
// Shared definitions for the ALU issue stage: funct3 codes, issue FSM encoding,
// and the payload layout {in0, in1, f3, f7, rd} carried through the skid buffer.
package g_rv_pkg;

  localparam logic [2:0] F3_ADD = 3'd0;
  localparam logic [2:0] F3_SLL = 3'd1;
  localparam logic [2:0] F3_SR  = 3'd5;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } issue_state_t;

  // Payload is packed MSB-first as {in0, in1, f3, f7, rd}.
  function automatic int issue_pl_w(input int xlen, input int reg_addr_w);
    return 2 * xlen + 3 + 1 + reg_addr_w;
  endfunction

endpackage

// File: rtl/g_skid_buf.sv
// Generic 2-entry valid/ready skid buffer; 1-cycle accept-to-valid latency.
// Backpressure: a second op is parked in the skid slot, then in_ready drops (registered).
module g_skid_buf
  import g_rv_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  issue_state_t state, state_nxt;
  logic         ready_q, ready_nxt;
  logic [W-1:0] main_q, skid_q;
  logic         load_main, load_skid, main_from_skid;
  logic         accept, handoff;

  assign in_ready  = ready_q;
  assign out_valid = (state != ST_EMPTY);
  assign out_data  = main_q;
  assign accept    = in_valid && ready_q;
  assign handoff   = out_valid && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_EMPTY;
      ready_q <= 1'b1;
    end else begin
      state   <= state_nxt;
      ready_q <= ready_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    load_main      = 1'b0;
    load_skid      = 1'b0;
    main_from_skid = 1'b0;
    if (flush) begin
      state_nxt = ST_EMPTY;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (accept) begin
            state_nxt = ST_FULL;
            load_main = 1'b1;
          end
        end
        ST_FULL: begin
          if (accept && !handoff) begin
            state_nxt = ST_SKID;
            load_skid = 1'b1;
          end else if (accept && handoff) begin
            load_main = 1'b1;
          end else if (handoff) begin
            state_nxt = ST_EMPTY;
          end
        end
        ST_SKID: begin
          if (handoff) begin
            state_nxt      = ST_FULL;
            main_from_skid = 1'b1;
          end
        end
        default: state_nxt = ST_EMPTY;
      endcase
    end
    ready_nxt = (state_nxt != ST_SKID);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_main) begin
        main_q <= in_data;
      end else if (main_from_skid) begin
        main_q <= skid_q;
      end
      if (load_skid) begin
        skid_q <= in_data;
      end
    end
  end

endmodule

// File: rtl/g_alu_issue.sv
// ALU issue stage: operand select/sanitise, then skid buffer; 1-cycle latency, stalls via in_ready_o.
// G_ISSUE_FORWARD_EN adds writeback forwarding onto rs1/rs2 at accept time.
module g_alu_issue
  import g_rv_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [XLEN-1:0]       rs1_val_i,
  input  logic [XLEN-1:0]       rs2_val_i,
  input  logic [XLEN-1:0]       imm_i,
  input  logic [REG_ADDR_W-1:0] rs1_addr_i,
  input  logic [REG_ADDR_W-1:0] rs2_addr_i,
  input  logic [REG_ADDR_W-1:0] rd_addr_i,
  input  logic [2:0]            funct3_i,
  input  logic                  funct7b5_i,
  input  logic                  is_imm_i,
`ifdef G_ISSUE_FORWARD_EN
  input  logic                  fwd_valid_i,
  input  logic [REG_ADDR_W-1:0] fwd_rd_i,
  input  logic [XLEN-1:0]       fwd_data_i,
`endif
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [XLEN-1:0]       alu_in0_o,
  output logic [XLEN-1:0]       alu_in1_o,
  output logic [2:0]            alu_funct3_o,
  output logic                  alu_funct7_o,
  output logic [REG_ADDR_W-1:0] out_rd_o
);

  localparam int PL_W = issue_pl_w(XLEN, REG_ADDR_W);

  logic [XLEN-1:0] rs1_eff, rs2_eff, in1_raw, in1;
  logic            f7;
  logic [PL_W-1:0] pl_in, pl_out;

`ifndef G_ISSUE_FORWARD_EN
  logic unused_addr;
  assign unused_addr = ^{rs1_addr_i, rs2_addr_i};
`endif

  always_comb begin
    rs1_eff = rs1_val_i;
    rs2_eff = rs2_val_i;
`ifdef G_ISSUE_FORWARD_EN
    if (fwd_valid_i && (fwd_rd_i == rs1_addr_i) && (rs1_addr_i != '0)) begin
      rs1_eff = fwd_data_i;
    end
    if (!is_imm_i && fwd_valid_i && (fwd_rd_i == rs2_addr_i) && (rs2_addr_i != '0)) begin
      rs2_eff = fwd_data_i;
    end
`endif
    in1_raw = is_imm_i ? imm_i : rs2_eff;
    in1     = in1_raw;
    // For I-type, bit 30 is an immediate bit except on SRAI, so ADDI never subtracts.
    f7 = 1'b0;
    if (!is_imm_i && ((funct3_i == F3_ADD) || (funct3_i == F3_SR))) begin
      f7 = funct7b5_i;
    end else if (is_imm_i && (funct3_i == F3_SR)) begin
      f7 = funct7b5_i;
    end
    if ((funct3_i == F3_SLL) || (funct3_i == F3_SR)) begin
      in1      = '0;
      in1[4:0] = in1_raw[4:0];
    end
  end

  assign pl_in = {rs1_eff, in1, funct3_i, f7, rd_addr_i};

  g_skid_buf #(
    .W(PL_W)
  ) u_skid (
    .clk       (clk_i),
    .rst       (rst_i),
    .flush     (flush_i),
    .in_valid  (in_valid_i),
    .in_ready  (in_ready_o),
    .in_data   (pl_in),
    .out_valid (out_valid_o),
    .out_ready (out_ready_i),
    .out_data  (pl_out)
  );

  assign {alu_in0_o, alu_in1_o, alu_funct3_o, alu_funct7_o, out_rd_o} = pl_out;

endmodule

// File: tb/tb_g_alu_issue.sv
// Directed bench for g_alu_issue: operand prep, skid backpressure, flush, async reset, forwarding.
module tb_g_alu_issue;

  logic        clk, rst, flush;
  logic        in_valid, in_ready;
  logic [31:0] rs1_val, rs2_val, imm;
  logic [4:0]  rs1_addr, rs2_addr, rd_addr;
  logic [2:0]  funct3;
  logic        funct7b5, is_imm;
  logic        out_valid, out_ready;
  logic [31:0] alu_in0, alu_in1;
  logic [2:0]  alu_funct3;
  logic        alu_funct7;
  logic [4:0]  out_rd;
`ifdef G_ISSUE_FORWARD_EN
  logic        fwd_valid;
  logic [4:0]  fwd_rd;
  logic [31:0] fwd_data;
`endif

  int n_vec = 0;
  int n_err = 0;

  g_alu_issue dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .flush_i      (flush),
    .in_valid_i   (in_valid),
    .in_ready_o   (in_ready),
    .rs1_val_i    (rs1_val),
    .rs2_val_i    (rs2_val),
    .imm_i        (imm),
    .rs1_addr_i   (rs1_addr),
    .rs2_addr_i   (rs2_addr),
    .rd_addr_i    (rd_addr),
    .funct3_i     (funct3),
    .funct7b5_i   (funct7b5),
    .is_imm_i     (is_imm),
`ifdef G_ISSUE_FORWARD_EN
    .fwd_valid_i  (fwd_valid),
    .fwd_rd_i     (fwd_rd),
    .fwd_data_i   (fwd_data),
`endif
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready),
    .alu_in0_o    (alu_in0),
    .alu_in1_o    (alu_in1),
    .alu_funct3_o (alu_funct3),
    .alu_funct7_o (alu_funct7),
    .out_rd_o     (out_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic op(input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] im,
                    input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] rd,
                    input logic [2:0] f3, input logic b30, input logic ii);
    in_valid = 1'b1;
    rs1_val  = r1;
    rs2_val  = r2;
    imm      = im;
    rs1_addr = a1;
    rs2_addr = a2;
    rd_addr  = rd;
    funct3   = f3;
    funct7b5 = b30;
    is_imm   = ii;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    op(0, 0, 0, 0, 0, 0, 0, 0, 0);
    in_valid = 1'b0;
`ifdef G_ISSUE_FORWARD_EN
    fwd_valid = 1'b0; fwd_rd = '0; fwd_data = '0;
`endif

    // Reset state
    @(negedge clk);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_in0", alu_in0, 32'd0);
    chk("rst_in1", alu_in1, 32'd0);
    chk("rst_rd", {27'b0, out_rd}, 32'd0);
    rst = 1'b0;

    // R-type SUB
    out_ready = 1'b1;
    op(32'd10, 32'd3, 32'd0, 5'd1, 5'd2, 5'd7, 3'd0, 1'b1, 1'b0);
    @(negedge clk);
    chk("sub_valid", {31'b0, out_valid}, 32'd1);
    chk("sub_in0", alu_in0, 32'd10);
    chk("sub_in1", alu_in1, 32'd3);
    chk("sub_f7", {31'b0, alu_funct7}, 32'd1);
    chk("sub_f3", {29'b0, alu_funct3}, 32'd0);
    chk("sub_rd", {27'b0, out_rd}, 32'd7);

    // ADDI with bit30 set never subtracts
    op(32'd0, 32'd0, 32'hFFFF_FC00, 5'd0, 5'd0, 5'd8, 3'd0, 1'b1, 1'b1);
    @(negedge clk);
    chk("addi_in1", alu_in1, 32'hFFFF_FC00);
    chk("addi_f7", {31'b0, alu_funct7}, 32'd0);
    chk("addi_rd", {27'b0, out_rd}, 32'd8);

    // SRAI: shamt masked, f7 kept
    op(32'h40, 32'd0, 32'h405, 5'd0, 5'd0, 5'd9, 3'd5, 1'b1, 1'b1);
    @(negedge clk);
    chk("srai_in1", alu_in1, 32'd5);
    chk("srai_f7", {31'b0, alu_funct7}, 32'd1);
    chk("srai_f3", {29'b0, alu_funct3}, 32'd5);

    // R-type SLL with bit30 set: f7 cleared, shamt masked
    op(32'd1, 32'h123, 32'd0, 5'd0, 5'd0, 5'd10, 3'd1, 1'b1, 1'b0);
    @(negedge clk);
    chk("sll_in1", alu_in1, 32'd3);
    chk("sll_f7", {31'b0, alu_funct7}, 32'd0);
    in_valid = 1'b0;
    @(negedge clk);
    chk("drain_valid", {31'b0, out_valid}, 32'd0);

    // Backpressure: A held, B skid, C refused until space
    out_ready = 1'b0;
    op(32'h111, 32'd0, 32'd0, 5'd0, 5'd0, 5'd1, 3'd0, 1'b0, 1'b0);
    @(negedge clk);
    chk("bp_a_valid", {31'b0, out_valid}, 32'd1);
    chk("bp_a_in0", alu_in0, 32'h111);
    chk("bp_rdy1", {31'b0, in_ready}, 32'd1);
    op(32'h222, 32'd0, 32'd0, 5'd0, 5'd0, 5'd2, 3'd0, 1'b0, 1'b0);
    @(negedge clk);
    chk("bp_a_hold1", alu_in0, 32'h111);
    chk("bp_rdy2", {31'b0, in_ready}, 32'd0);
    op(32'h333, 32'd0, 32'd0, 5'd0, 5'd0, 5'd3, 3'd0, 1'b0, 1'b0);
    @(negedge clk);
    chk("bp_a_hold2", alu_in0, 32'h111);
    chk("bp_a_rd", {27'b0, out_rd}, 32'd1);
    chk("bp_rdy3", {31'b0, in_ready}, 32'd0);
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_b_in0", alu_in0, 32'h222);
    chk("bp_b_rd", {27'b0, out_rd}, 32'd2);
    chk("bp_rdy4", {31'b0, in_ready}, 32'd1);
    @(negedge clk);
    chk("bp_c_in0", alu_in0, 32'h333);
    chk("bp_c_valid", {31'b0, out_valid}, 32'd1);
    in_valid = 1'b0;
    @(negedge clk);
    chk("bp_empty", {31'b0, out_valid}, 32'd0);

    // Flush while in SKID with a new op on the input
    out_ready = 1'b0;
    op(32'h444, 32'd0, 32'd0, 5'd0, 5'd0, 5'd4, 3'd0, 1'b0, 1'b0);
    @(negedge clk);
    op(32'h555, 32'd0, 32'd0, 5'd0, 5'd0, 5'd5, 3'd0, 1'b0, 1'b0);
    @(negedge clk);
    chk("fl_skid_rdy", {31'b0, in_ready}, 32'd0);
    flush = 1'b1;
    op(32'h666, 32'd0, 32'd0, 5'd0, 5'd0, 5'd6, 3'd0, 1'b0, 1'b0);
    @(negedge clk);
    flush = 1'b0;
    in_valid = 1'b0;
    chk("fl_valid", {31'b0, out_valid}, 32'd0);
    chk("fl_rdy", {31'b0, in_ready}, 32'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("fl_stays_empty", {31'b0, out_valid}, 32'd0);
    end

    // Async reset while FULL, between clock edges
    out_ready = 1'b0;
    op(32'h777, 32'h88, 32'd0, 5'd0, 5'd0, 5'd3, 3'd5, 1'b1, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    chk("ar_full_valid", {31'b0, out_valid}, 32'd1);
    chk("ar_full_in1", alu_in1, 32'd8);
    chk("ar_full_f7", {31'b0, alu_funct7}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("ar_valid", {31'b0, out_valid}, 32'd0);
    chk("ar_in0", alu_in0, 32'd0);
    chk("ar_in1", alu_in1, 32'd0);
    chk("ar_f3", {29'b0, alu_funct3}, 32'd0);
    chk("ar_f7", {31'b0, alu_funct7}, 32'd0);
    chk("ar_rd", {27'b0, out_rd}, 32'd0);
    chk("ar_rdy", {31'b0, in_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    op(32'h999, 32'd0, 32'd0, 5'd0, 5'd0, 5'd12, 3'd0, 1'b0, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    chk("post_rst_in0", alu_in0, 32'h999);
    chk("post_rst_rd", {27'b0, out_rd}, 32'd12);

`ifdef G_ISSUE_FORWARD_EN
    fwd_valid = 1'b1; fwd_rd = 5'd5; fwd_data = 32'h1234;
    op(32'h99, 32'h42, 32'd0, 5'd5, 5'd6, 5'd1, 3'd0, 1'b0, 1'b0);
    @(negedge clk);
    chk("fwd_rs1", alu_in0, 32'h1234);
    chk("fwd_rs2_nomatch", alu_in1, 32'h42);
    op(32'h99, 32'h42, 32'd0, 5'd6, 5'd5, 5'd1, 3'd0, 1'b0, 1'b0);
    @(negedge clk);
    chk("fwd_rs2", alu_in1, 32'h1234);
    chk("fwd_rs1_nomatch", alu_in0, 32'h99);
    op(32'h99, 32'h42, 32'h10, 5'd6, 5'd5, 5'd1, 3'd0, 1'b0, 1'b1);
    @(negedge clk);
    chk("fwd_imm_ignored", alu_in1, 32'h10);
    fwd_rd = 5'd0;
    op(32'h77, 32'h42, 32'd0, 5'd0, 5'd6, 5'd1, 3'd0, 1'b0, 1'b0);
    @(negedge clk);
    chk("fwd_x0", alu_in0, 32'h77);
    in_valid = 1'b0;
    fwd_valid = 1'b0;
    @(negedge clk);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
